// File: rtl/decode_stage.sv
// Decode stage: opcode decode, register-file addressing, pending-write
// scoreboard with writeback bypass, and a registered valid/ready output bundle.
module decode_stage #(
    parameter int INSTR_W = 32,
    parameter int OPC_W   = 6,
    parameter int DATA_W  = 16,
    parameter int NREGS   = 32,
    parameter int ADDR_W  = $clog2(NREGS),
    parameter int IMM_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0] rf_addr1,
    output logic [ADDR_W-1:0] rf_addr2,
    input  logic [DATA_W-1:0] rf_data1,
    input  logic [DATA_W-1:0] rf_data2,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OPC_W-1:0]  alu_op,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [ADDR_W-1:0] rd,
    output logic              reg_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic [15:0]       stall_count
);

    localparam logic [OPC_W-1:0] OP_MOVI  = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_LOAD  = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_STORE = OPC_W'(3);

    typedef enum logic {S_EMPTY, S_FULL} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [NREGS-1:0]    r_pend;
    logic [NREGS-1:0]    w_pend_nxt;
    logic [OPC_W-1:0]    r_alu_op;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [ADDR_W-1:0]   r_rd;
    logic                r_rw;
    logic                r_mr;
    logic                r_mw;
    logic [15:0]         r_stall;

    logic [OPC_W-1:0]    w_op;
    logic [ADDR_W-1:0]   w_rs1;
    logic [ADDR_W-1:0]   w_rs2;
    logic [ADDR_W-1:0]   w_rd;
    logic [DATA_W-1:0]   w_imm;
    logic [DATA_W-1:0]   w_src1;
    logic [DATA_W-1:0]   w_src2;
    logic [DATA_W-1:0]   w_a;
    logic [DATA_W-1:0]   w_b;
    logic                w_use1;
    logic                w_use2;
    logic                w_rw;
    logic                w_mr;
    logic                w_mw;
    logic                w_byp1;
    logic                w_byp2;
    logic                w_haz;
    logic                w_accept;
    logic                w_unused;

    assign w_op     = instr[INSTR_W-1 -: OPC_W];
    assign w_rs1    = instr[ADDR_W-1:0];
    assign w_rs2    = instr[2*ADDR_W-1:ADDR_W];
    assign w_rd     = instr[INSTR_W-OPC_W-1 -: ADDR_W];
    assign w_imm    = DATA_W'(instr[IMM_W-1:0]);
    assign w_unused = ^instr;

    assign rf_addr1 = w_rs1;
    assign rf_addr2 = w_rs2;

    // A retiring write to a source both forwards its data and hides the hazard
    assign w_byp1 = wb_valid && (wb_addr == w_rs1);
    assign w_byp2 = wb_valid && (wb_addr == w_rs2);
    assign w_src1 = w_byp1 ? wb_data : rf_data1;
    assign w_src2 = w_byp2 ? wb_data : rf_data2;

    always_comb begin
        w_use1 = 1'b0;
        w_use2 = 1'b0;
        w_rw   = 1'b1;
        w_mr   = 1'b0;
        w_mw   = 1'b0;
        w_a    = w_src1;
        w_b    = w_src2;
        case (w_op)
            OP_MOVI: begin
                w_a = w_imm;
                w_b = '0;
            end
            OP_LOAD: begin
                w_a  = w_imm;
                w_b  = '0;
                w_mr = 1'b1;
            end
            OP_STORE: begin
                w_b    = w_imm;
                w_rw   = 1'b0;
                w_mw   = 1'b1;
                w_use1 = 1'b1;
            end
            default: begin
                w_use1 = 1'b1;
                w_use2 = 1'b1;
            end
        endcase
    end

    assign w_haz = (w_use1 && r_pend[w_rs1] && !w_byp1)
                || (w_use2 && r_pend[w_rs2] && !w_byp2);

    assign out_valid = (r_state == S_FULL);
    assign in_ready  = !reset && !w_haz && (!out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_EMPTY: if (w_accept) w_next = S_FULL;
            S_FULL:  if (out_ready && !w_accept) w_next = S_EMPTY;
            default: w_next = S_EMPTY;
        endcase
    end

    // Clear first so a same-cycle new producer keeps its pending bit
    always_comb begin
        w_pend_nxt = r_pend;
        if (wb_valid) w_pend_nxt[wb_addr] = 1'b0;
        if (w_accept && w_rw) w_pend_nxt[w_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_EMPTY;
            r_pend  <= '0;
            r_stall <= '0;
        end else begin
            r_state <= w_next;
            r_pend  <= w_pend_nxt;
            if (in_valid && w_haz && (r_stall != 16'hFFFF))
                r_stall <= r_stall + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_alu_op <= '1;
            r_a      <= '0;
            r_b      <= '0;
            r_rd     <= '0;
            r_rw     <= 1'b0;
            r_mr     <= 1'b0;
            r_mw     <= 1'b0;
        end else if (w_accept) begin
            r_alu_op <= w_op;
            r_a      <= w_a;
            r_b      <= w_b;
            r_rd     <= w_rd;
            r_rw     <= w_rw;
            r_mr     <= w_mr;
            r_mw     <= w_mw;
        end
    end

    assign alu_op      = r_alu_op;
    assign a           = r_a;
    assign b           = r_b;
    assign rd          = r_rd;
    assign reg_write   = r_rw;
    assign mem_read    = r_mr;
    assign mem_write   = r_mw;
    assign stall_count = r_stall;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed instructions push expected
// bundles; a negedge monitor pops and compares on every output handshake.
module tb_decode_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [4:0]  rf_addr1;
    logic [4:0]  rf_addr2;
    logic [15:0] rf_data1;
    logic [15:0] rf_data2;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [15:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  alu_op;
    logic [15:0] a;
    logic [15:0] b;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] stall_count;

    int checks = 0;
    int failures = 0;
    int npop = 0;
    logic [45:0] q[$];
    logic [15:0] rf [32];

    decode_stage dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .rf_addr1(rf_addr1), .rf_addr2(rf_addr2),
        .rf_data1(rf_data1), .rf_data2(rf_data2),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_op(alu_op), .a(a), .b(b), .rd(rd),
        .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .stall_count(stall_count)
    );

    assign rf_data1 = rf[rf_addr1];
    assign rf_data2 = rf[rf_addr2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [45:0] pk(logic [5:0] op, logic [15:0] av,
        logic [15:0] bv, logic [4:0] rdv, logic rw, logic mr, logic mw);
        return {op, av, bv, rdv, rw, mr, mw};
    endfunction

    function automatic logic [31:0] mk(logic [5:0] op, logic [4:0] rdv,
        logic [4:0] rs2, logic [4:0] rs1);
        return {op, rdv, 11'd0, rs2, rs1};
    endfunction

    function automatic logic [31:0] mki(logic [5:0] op, logic [4:0] rdv,
        logic [15:0] imm);
        return {op, rdv, 5'd0, imm};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
        input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL mon_unexpected actual=%0h required=none",
                    {alu_op, a, b, rd, reg_write, mem_read, mem_write});
            end else begin
                npop++;
                chk("bundle",
                    {alu_op, a, b, rd, reg_write, mem_read, mem_write},
                    q.pop_front());
            end
        end
    end

    task automatic send(input logic [31:0] ins, input logic [45:0] exp,
        output int waits);
        in_valid = 1'b1;
        instr = ins;
        waits = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waits++;
            if (waits > 20) begin
                chk("send_timeout", 64'(waits), 64'd0);
                @(posedge clk);
                #1 in_valid = 1'b0;
                return;
            end
        end
        q.push_back(exp);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    logic [31:0] b2b_i [4];
    logic [45:0] b2b_e [4];
    int w;

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 16'(i * 257);
        rf[5] = 16'h00AA;
        b2b_i[0] = mk(6'h04, 5'd16, 5'd11, 5'd10);
        b2b_e[0] = pk(6'h04, 16'h0A0A, 16'h0B0B, 5'd16, 1, 0, 0);
        b2b_i[1] = mk(6'h01, 5'd17, 5'd12, 5'd11);
        b2b_e[1] = pk(6'h01, 16'h0B0B, 16'h0C0C, 5'd17, 1, 0, 0);
        b2b_i[2] = mk(6'h10, 5'd18, 5'd13, 5'd12);
        b2b_e[2] = pk(6'h10, 16'h0C0C, 16'h0D0D, 5'd18, 1, 0, 0);
        b2b_i[3] = mk(6'h3F, 5'd19, 5'd14, 5'd13);
        b2b_e[3] = pk(6'h3F, 16'h0D0D, 16'h0E0E, 5'd19, 1, 0, 0);

        reset = 1'b1;
        in_valid = 1'b0;
        instr = '0;
        wb_valid = 1'b0;
        wb_addr = '0;
        wb_data = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_alu_op", 64'(alu_op), 64'h3F);
        chk("rst_ab", {a, b}, 64'd0);
        chk("rst_rd_flags", {rd, reg_write, mem_read, mem_write}, 64'd0);
        chk("rst_stall", 64'(stall_count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        out_ready = 1'b1;

        // MOVI r3 = 0x1234
        send(32'h0060_1234, pk(6'h00, 16'h1234, 16'h0, 5'd3, 1, 0, 0), w);
        chk("movi_wait", 64'(w), 64'd0);
        chk("movi_latency", 64'(out_valid), 64'd1);

        // RAW on r3: stall, then writeback bypass
        in_valid = 1'b1;
        instr = mk(6'h01, 5'd4, 5'd1, 5'd3);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("raw_ready", 64'(in_ready), 64'd0);
            chk("raw_stall", 64'(stall_count), 64'(k));
        end
        @(posedge clk);
        #1 wb_valid = 1'b1;
        wb_addr = 5'd3;
        wb_data = 16'h1234;
        send(mk(6'h01, 5'd4, 5'd1, 5'd3),
             pk(6'h01, 16'h1234, 16'h0101, 5'd4, 1, 0, 0), w);
        wb_valid = 1'b0;
        chk("byp_wait", 64'(w), 64'd0);
        chk("raw_stall_total", 64'(stall_count), 64'd3);

        for (int i = 0; i < 4; i++) begin
            send(b2b_i[i], b2b_e[i], w);
            chk("b2b_wait", 64'(w), 64'd0);
        end

        // Downstream backpressure holds the last bundle
        out_ready = 1'b0;
        in_valid = 1'b1;
        instr = mk(6'h07, 5'd20, 5'd15, 5'd14);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_ready", 64'(in_ready), 64'd0);
            chk("hold_bundle", {alu_op, a, b, rd}, {6'h3F, 16'h0D0D, 16'h0E0E, 5'd19});
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(mk(6'h07, 5'd20, 5'd15, 5'd14),
             pk(6'h07, 16'h0E0E, 16'h0F0F, 5'd20, 1, 0, 0), w);
        chk("hold_release_wait", 64'(w), 64'd0);

        send(mki(6'h02, 5'd22, 16'h0BCD),
             pk(6'h02, 16'h0BCD, 16'h0, 5'd22, 1, 1, 0), w);
        // STORE r5, imm 0x0205; rs2 field (r16) is pending but unused
        send(mki(6'h03, 5'd9, 16'h0205),
             pk(6'h03, 16'h00AA, 16'h0205, 5'd9, 0, 0, 1), w);
        chk("store_unused_src", 64'(w), 64'd0);
        send(mk(6'h01, 5'd23, 5'd10, 5'd9),
             pk(6'h01, 16'h0909, 16'h0A0A, 5'd23, 1, 0, 0), w);
        chk("store_no_pend", 64'(w), 64'd0);
        send(mki(6'h00, 5'd24, 16'h0010),
             pk(6'h00, 16'h0010, 16'h0, 5'd24, 1, 0, 0), w);
        chk("movi_unused_src", 64'(w), 64'd0);

        // Same-cycle set and clear of r7: set must win
        wb_valid = 1'b1;
        wb_addr = 5'd7;
        wb_data = 16'h7777;
        send(mki(6'h00, 5'd7, 16'h0777),
             pk(6'h00, 16'h0777, 16'h0, 5'd7, 1, 0, 0), w);
        wb_valid = 1'b0;
        in_valid = 1'b1;
        instr = mk(6'h01, 5'd25, 5'd10, 5'd7);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("set_wins_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1 wb_valid = 1'b1;
        wb_addr = 5'd7;
        wb_data = 16'hBEEF;
        send(mk(6'h01, 5'd25, 5'd10, 5'd7),
             pk(6'h01, 16'hBEEF, 16'h0A0A, 5'd25, 1, 0, 0), w);
        wb_valid = 1'b0;
        chk("r7_byp_wait", 64'(w), 64'd0);
        chk("stall_total", 64'(stall_count), 64'd5);

        // Reset with a held bundle and pending bits
        send(mki(6'h00, 5'd8, 16'h0888),
             pk(6'h00, 16'h0888, 16'h0, 5'd8, 1, 0, 0), w);
        out_ready = 1'b0;
        reset = 1'b1;
        q.delete();
        @(negedge clk);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_alu_op", 64'(alu_op), 64'h3F);
        chk("midrst_stall", 64'(stall_count), 64'd0);
        chk("midrst_flags", {a, b, rd, reg_write}, 64'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(mk(6'h01, 5'd26, 5'd4, 5'd8),
             pk(6'h01, 16'h0808, 16'h0404, 5'd26, 1, 0, 0), w);
        chk("midrst_pend_clear", 64'(w), 64'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 64'(q.size()), 64'd0);
        chk("pop_count", 64'(npop), 64'd14);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
